// File: rtl/riscv_pkg.sv
// Shared types for the L0 cache datapath.
package riscv_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } l0_inval_state_e;

endpackage

// File: rtl/l0_cache_invalidate_sequencer.sv
// Owns the L0 cache write port during invalidation: full-cache sweeps on
// fence requests, single-line invalidates, and pass-through of controller writes.
module l0_cache_invalidate_sequencer
   import riscv_pkg::*;
#(
   parameter int              XLEN            = 32,
   parameter int              CacheIndexWidth = 7,
   parameter int              CacheTagWidth   = 7,
   parameter logic [XLEN-1:0] MMIO_ADDR       = 32'h4000_0000
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_sweep_req,
   input  logic                       i_line_inval_valid,
   input  logic [XLEN-1:0]            i_line_inval_address,
   output logic                       o_line_inval_ready,
   output logic                       o_busy,
   output logic                       o_sweep_done,
   input  logic                       i_ctrl_write_enable,
   input  logic [XLEN/8-1:0]          i_ctrl_byte_write_enable,
   input  logic [CacheIndexWidth-1:0] i_ctrl_write_index,
   input  logic [XLEN-1:0]            i_ctrl_write_data,
   input  logic [CacheTagWidth-1:0]   i_ctrl_write_tag,
   input  logic [XLEN/8-1:0]          i_ctrl_write_valid,
   output logic                       o_cache_write_enable,
   output logic [XLEN/8-1:0]          o_cache_byte_write_enable,
   output logic [CacheIndexWidth-1:0] o_cache_write_index,
   output logic [XLEN-1:0]            o_cache_write_data,
   output logic [CacheTagWidth-1:0]   o_cache_write_tag,
   output logic [XLEN/8-1:0]          o_cache_write_valid
);

   l0_inval_state_e              r_state;
   l0_inval_state_e              w_stateNext;
   logic [CacheIndexWidth-1:0]   r_sweepIdx;
   logic                         r_rerun;
   logic                         w_sweepWrite;
   logic                         w_lineWrite;
   logic                         w_lastIdx;
   logic [CacheIndexWidth-1:0]   w_lineIndex;

   assign w_lastIdx   = (r_sweepIdx == {CacheIndexWidth{1'b1}});
   assign w_lineIndex = i_line_inval_address[2 +: CacheIndexWidth];

   // Controller writes always own the port; our own writes only fill idle cycles.
   always_comb begin
      w_stateNext               = r_state;
      w_sweepWrite              = 1'b0;
      w_lineWrite               = 1'b0;
      o_busy                    = 1'b0;
      o_sweep_done              = 1'b0;
      o_line_inval_ready        = 1'b0;
      o_cache_write_enable      = i_ctrl_write_enable;
      o_cache_byte_write_enable = i_ctrl_byte_write_enable;
      o_cache_write_index       = i_ctrl_write_index;
      o_cache_write_data        = i_ctrl_write_data;
      o_cache_write_tag         = i_ctrl_write_tag;
      o_cache_write_valid       = i_ctrl_write_valid;

      case (r_state)
         IDLE: begin
            o_line_inval_ready = i_rst_n & ~i_sweep_req & ~i_ctrl_write_enable;
            w_lineWrite = o_line_inval_ready & i_line_inval_valid &
                          (i_line_inval_address < MMIO_ADDR);
            if (i_sweep_req) begin
               w_stateNext = SWEEP;
            end
         end
         SWEEP: begin
            o_busy       = 1'b1;
            w_sweepWrite = ~i_ctrl_write_enable;
            if (w_sweepWrite && w_lastIdx && !(r_rerun || i_sweep_req)) begin
               w_stateNext = DONE;
            end
         end
         DONE: begin
            o_busy       = 1'b1;
            o_sweep_done = 1'b1;
            w_stateNext  = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase

      if (w_sweepWrite || w_lineWrite) begin
         o_cache_write_enable      = 1'b1;
         o_cache_byte_write_enable = '1;
         o_cache_write_index       = w_sweepWrite ? r_sweepIdx : w_lineIndex;
         o_cache_write_data        = '0;
         o_cache_write_tag         = '0;
         o_cache_write_valid       = '0;
      end
   end

   // A request that arrives mid-sweep is remembered and replayed as a fresh pass.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= IDLE;
         r_sweepIdx <= '0;
         r_rerun    <= 1'b0;
      end else begin
         r_state <= w_stateNext;
         case (r_state)
            IDLE: begin
               if (i_sweep_req) begin
                  r_sweepIdx <= '0;
                  r_rerun    <= 1'b0;
               end
            end
            SWEEP: begin
               if (w_sweepWrite && w_lastIdx) begin
                  r_sweepIdx <= '0;
                  r_rerun    <= 1'b0;
               end else begin
                  if (w_sweepWrite) begin
                     r_sweepIdx <= r_sweepIdx + 1'b1;
                  end
                  if (i_sweep_req) begin
                     r_rerun <= 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assert property (@(posedge i_clk) disable iff (!i_rst_n)
      $onehot0({w_sweepWrite, w_lineWrite, i_ctrl_write_enable}));

   assert property (@(posedge i_clk)
      o_sweep_done |-> $past(r_state == SWEEP));

   assert property (@(posedge i_clk)
      ($past(i_rst_n) && (r_sweepIdx != $past(r_sweepIdx))) |-> $past(w_sweepWrite));

endmodule

// File: tb/tb_l0_cache_invalidate_sequencer.sv
// Directed bench for the L0 invalidate sequencer: reset, line invalidates,
// plain/conflicted/re-armed sweeps and reset mid-sweep.
module tb_l0_cache_invalidate_sequencer;

   logic        i_clk;
   logic        i_rst_n;
   logic        i_sweep_req;
   logic        i_line_inval_valid;
   logic [31:0] i_line_inval_address;
   logic        o_line_inval_ready;
   logic        o_busy;
   logic        o_sweep_done;
   logic        i_ctrl_write_enable;
   logic [3:0]  i_ctrl_byte_write_enable;
   logic [6:0]  i_ctrl_write_index;
   logic [31:0] i_ctrl_write_data;
   logic [6:0]  i_ctrl_write_tag;
   logic [3:0]  i_ctrl_write_valid;
   logic        o_cache_write_enable;
   logic [3:0]  o_cache_byte_write_enable;
   logic [6:0]  o_cache_write_index;
   logic [31:0] o_cache_write_data;
   logic [6:0]  o_cache_write_tag;
   logic [3:0]  o_cache_write_valid;

   int checks   = 0;
   int failures = 0;

   localparam logic [31:0] CtrlData = 32'hDEAD_BEEF;

   l0_cache_invalidate_sequencer dut (
      .i_clk                     (i_clk),
      .i_rst_n                   (i_rst_n),
      .i_sweep_req               (i_sweep_req),
      .i_line_inval_valid        (i_line_inval_valid),
      .i_line_inval_address      (i_line_inval_address),
      .o_line_inval_ready        (o_line_inval_ready),
      .o_busy                    (o_busy),
      .o_sweep_done              (o_sweep_done),
      .i_ctrl_write_enable       (i_ctrl_write_enable),
      .i_ctrl_byte_write_enable  (i_ctrl_byte_write_enable),
      .i_ctrl_write_index        (i_ctrl_write_index),
      .i_ctrl_write_data         (i_ctrl_write_data),
      .i_ctrl_write_tag          (i_ctrl_write_tag),
      .i_ctrl_write_valid        (i_ctrl_write_valid),
      .o_cache_write_enable      (o_cache_write_enable),
      .o_cache_byte_write_enable (o_cache_byte_write_enable),
      .o_cache_write_index       (o_cache_write_index),
      .o_cache_write_data        (o_cache_write_data),
      .o_cache_write_tag         (o_cache_write_tag),
      .o_cache_write_valid       (o_cache_write_valid)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Advance one cycle, drive new inputs just after the edge, then let them settle.
   task automatic applyStimulus(input logic rstN, input logic sweepReq,
                                input logic ctrlWe, input logic [6:0] ctrlIdx,
                                input logic lineValid, input logic [31:0] lineAddr);
      @(posedge i_clk);
      #1;
      i_rst_n              = rstN;
      i_sweep_req          = sweepReq;
      i_ctrl_write_enable  = ctrlWe;
      i_ctrl_write_index   = ctrlIdx;
      i_line_inval_valid   = lineValid;
      i_line_inval_address = lineAddr;
      #1;
   endtask

   task automatic checkSweepWrite(input string tag, input int idx);
      checkOutput({tag, "_busy"}, 32'(o_busy), 32'd1);
      checkOutput({tag, "_done"}, 32'(o_sweep_done), 32'd0);
      checkOutput({tag, "_we"}, 32'(o_cache_write_enable), 32'd1);
      checkOutput({tag, "_idx"}, 32'(o_cache_write_index), 32'(idx));
      checkOutput({tag, "_valid"}, 32'(o_cache_write_valid), 32'h0);
      checkOutput({tag, "_bwe"}, 32'(o_cache_byte_write_enable), 32'hF);
      checkOutput({tag, "_data"}, o_cache_write_data, 32'h0);
   endtask

   // Request in cycle 0; optional controller conflict at one sweep index and an
   // optional re-arm pulse at one index of the first pass; done expected at doneCycle.
   task automatic runSweep(input string tag, input int conflictIdx,
                           input int rerunIdx, input int doneCycle);
      int  expIdx;
      bit  conflictUsed;
      bit  rerunUsed;
      bit  isConflict;
      expIdx       = 0;
      conflictUsed = 1'b0;
      rerunUsed    = 1'b0;
      applyStimulus(1'b1, 1'b1, 1'b0, 7'h22, 1'b0, 32'h0);
      checkOutput({tag, "_c0_busy"}, 32'(o_busy), 32'd0);
      checkOutput({tag, "_c0_ready"}, 32'(o_line_inval_ready), 32'd0);
      for (int cyc = 1; cyc < doneCycle; cyc++) begin
         isConflict = (!conflictUsed && expIdx == conflictIdx);
         applyStimulus(1'b1, (!rerunUsed && expIdx == rerunIdx), isConflict,
                       isConflict ? 7'h10 : 7'h22, 1'b0, 32'h0);
         if (!rerunUsed && expIdx == rerunIdx) rerunUsed = 1'b1;
         if (isConflict) begin
            conflictUsed = 1'b1;
            checkOutput({tag, "_conf_busy"}, 32'(o_busy), 32'd1);
            checkOutput({tag, "_conf_idx"}, 32'(o_cache_write_index), 32'h10);
            checkOutput({tag, "_conf_data"}, o_cache_write_data, CtrlData);
            checkOutput({tag, "_conf_valid"}, 32'(o_cache_write_valid), 32'h5);
         end else begin
            checkSweepWrite(tag, expIdx);
            expIdx = (expIdx + 1) % 128;
         end
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 7'h22, 1'b0, 32'h0);
      checkOutput({tag, "_done_pulse"}, 32'(o_sweep_done), 32'd1);
      checkOutput({tag, "_done_busy"}, 32'(o_busy), 32'd1);
      checkOutput({tag, "_done_we"}, 32'(o_cache_write_enable), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 7'h22, 1'b0, 32'h0);
      checkOutput({tag, "_after_done"}, 32'(o_sweep_done), 32'd0);
      checkOutput({tag, "_after_busy"}, 32'(o_busy), 32'd0);
   endtask

   initial begin
      int doneSeen;
      i_rst_n                  = 1'b0;
      i_sweep_req              = 1'b0;
      i_line_inval_valid       = 1'b0;
      i_line_inval_address     = 32'h0;
      i_ctrl_write_enable      = 1'b0;
      i_ctrl_byte_write_enable = 4'h3;
      i_ctrl_write_index       = 7'h22;
      i_ctrl_write_data        = CtrlData;
      i_ctrl_write_tag         = 7'h15;
      i_ctrl_write_valid       = 4'h5;

      applyStimulus(1'b0, 1'b0, 1'b0, 7'h22, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 7'h22, 1'b0, 32'h0);
      checkOutput("rst_ready", 32'(o_line_inval_ready), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 7'h22, 1'b0, 32'h0);
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_done", 32'(o_sweep_done), 32'd0);
      checkOutput("idle_ready", 32'(o_line_inval_ready), 32'd1);
      checkOutput("pass_we", 32'(o_cache_write_enable), 32'd0);
      checkOutput("pass_idx", 32'(o_cache_write_index), 32'h22);
      checkOutput("pass_data", o_cache_write_data, CtrlData);
      checkOutput("pass_tag", 32'(o_cache_write_tag), 32'h15);
      checkOutput("pass_bwe", 32'(o_cache_byte_write_enable), 32'h3);

      $display("[TB] line invalidate");
      applyStimulus(1'b1, 1'b0, 1'b0, 7'h22, 1'b1, 32'h0000_0104);
      checkOutput("line_ready", 32'(o_line_inval_ready), 32'd1);
      checkOutput("line_we", 32'(o_cache_write_enable), 32'd1);
      checkOutput("line_idx", 32'(o_cache_write_index), 32'h41);
      checkOutput("line_valid", 32'(o_cache_write_valid), 32'h0);
      checkOutput("line_tag", 32'(o_cache_write_tag), 32'h0);
      checkOutput("line_data", o_cache_write_data, 32'h0);
      applyStimulus(1'b1, 1'b0, 1'b1, 7'h10, 1'b1, 32'h0000_0104);
      checkOutput("line_conf_ready", 32'(o_line_inval_ready), 32'd0);
      checkOutput("line_conf_idx", 32'(o_cache_write_index), 32'h10);
      checkOutput("line_conf_data", o_cache_write_data, CtrlData);
      applyStimulus(1'b1, 1'b0, 1'b0, 7'h22, 1'b1, 32'h0000_0104);
      checkOutput("line_retry_ready", 32'(o_line_inval_ready), 32'd1);
      checkOutput("line_retry_idx", 32'(o_cache_write_index), 32'h41);
      applyStimulus(1'b1, 1'b0, 1'b0, 7'h22, 1'b1, 32'h4000_0000);
      checkOutput("mmio_ready", 32'(o_line_inval_ready), 32'd1);
      checkOutput("mmio_we", 32'(o_cache_write_enable), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 7'h22, 1'b1, 32'h3FFF_FFFC);
      checkOutput("below_mmio_we", 32'(o_cache_write_enable), 32'd1);
      checkOutput("below_mmio_idx", 32'(o_cache_write_index), 32'h7F);

      $display("[TB] sweeps");
      runSweep("plain", -1, -1, 129);
      runSweep("conflict", 5, -1, 130);
      runSweep("rerun", -1, 40, 257);

      $display("[TB] reset mid-sweep");
      applyStimulus(1'b1, 1'b1, 1'b0, 7'h22, 1'b0, 32'h0);
      for (int cyc = 1; cyc <= 60; cyc++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 7'h22, 1'b0, 32'h0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 7'h22, 1'b0, 32'h0);
      checkOutput("midrst_idx60", 32'(o_cache_write_index), 32'd60);
      applyStimulus(1'b1, 1'b0, 1'b1, 7'h10, 1'b0, 32'h0);
      checkOutput("midrst_busy", 32'(o_busy), 32'd0);
      checkOutput("midrst_pass_idx", 32'(o_cache_write_index), 32'h10);
      checkOutput("midrst_pass_data", o_cache_write_data, CtrlData);
      doneSeen = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         applyStimulus(1'b1, 1'b0, 1'b0, 7'h22, 1'b0, 32'h0);
         if (o_sweep_done || o_busy) doneSeen++;
      end
      checkOutput("midrst_no_done", 32'(doneSeen), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
